if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage for the MIPS core. It sits directly upstream of the instruction memory: it owns the program counter, drives the memory's 4-bit word address, and captures the returned 32-bit instruction into the IF/ID pipeline register. It handles decode-stage stall requests, redirects (branch or jump target, computed downstream) and end-of-program halt.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; must be word-aligned.
PROG_LEN, 9, number of valid instruction words in memory; legal range 1..16.
NOP_WORD, 32'h0000_0000, instruction value inserted into IF/ID for bubbles and flushes.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold PC and IF/ID register this cycle.
redirect_valid  in  1  load redirect_target into the PC and flush IF/ID.
redirect_target  in  32  byte address of the branch or jump target.
im_instruction  in  32  instruction word returned combinationally by instruction memory.
im_address  out  4  word index to instruction memory, equal to pc[5:2].
if_instr  out  32  IF/ID instruction register.
if_pc  out  32  IF/ID register: byte address of if_instr.
if_pc_plus4  out  32  IF/ID register: if_pc + 4.
if_valid  out  1  IF/ID register holds a real instruction.
halted  out  1  fetch has run past PROG_LEN and is idle.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high, sampled on the rising edge, and overrides every other input.
- Reset values: pc = RESET_PC; state = FILL; if_instr = NOP_WORD; if_pc = 0; if_pc_plus4 = 0; if_valid = 0; halted = 0.
- im_address is combinational from the PC register (pc[5:2]). im_instruction is used in the same cycle. Latency is 1 cycle from the PC value to if_instr.
- Defined range: in_range = (pc >> 2) < PROG_LEN. PC bits [1:0] are always 0; redirect_target[1:0] are forced to 0 when loaded.
- States:
  - FILL: one bubble cycle after reset. IF/ID gets NOP, if_valid = 0, PC held. Next state is RUN, or HALT if RESET_PC is out of range.
  - RUN, normal cycle: if_instr <= im_instruction; if_pc <= pc; if_pc_plus4 <= pc + 4; if_valid <= 1; pc <= pc + 4. If (pc + 4) is out of range, go to HALT (the last word is still latched valid).
  - HALT: halted = 1; IF/ID gets NOP with if_valid = 0; PC held.
- Priority, highest first: reset > redirect_valid > stall > normal.
- Redirect (any state, including during stall, FILL or HALT):
  - pc <= {target[31:2], 2'b00}.
  - IF/ID flushed: NOP, if_valid = 0; if_pc and if_pc_plus4 hold.
  - Next state is RUN if the target is in range, otherwise HALT. halted follows the state on the next cycle.
- Stall in RUN without redirect: PC and all IF/ID registers hold; state holds. Stall in FILL or HALT has no additional effect.
- PC arithmetic is 32-bit, wrapping modulo 2^32. Addresses beyond PROG_LEN never reach memory as valid fetches; im_address may still show them.
- halted is a registered output, high exactly while state = HALT.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds two outputs, perf_fetch_count (16-bit) and perf_stall_count (16-bit). Both are cleared by reset.
  - perf_fetch_count increments on every cycle that loads if_valid = 1 from a fetch.
  - perf_stall_count increments on every RUN cycle with stall = 1 and redirect_valid = 0.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then run freely with PROG_LEN = 9 and memory modelled as word i = 32'h1000_0000 + i. Required: the cycle after reset has if_valid = 0. Then if_instr = 32'h1000_0000..32'h1000_0008 on consecutive cycles, with if_pc = 0..32 in steps of 4. The cycle after word 8, halted = 1 and if_valid = 0.
2. Stall held for 3 cycles while if_pc = 8. Required: if_instr, if_pc and im_address (= 3) hold for all 3 cycles, and fetch resumes at pc = 12. With FETCH_PERF_EN, perf_stall_count = 3.
3. Assert redirect_valid with target 32'h0000_0004 while pc = 20. Required: the next cycle has if_valid = 0 and im_address = 1. The following cycle has if_instr = word 1 and if_pc = 4.
4. Assert redirect_valid and stall together, with target 32'h0000_001E. Required: redirect wins, pc = 32'h1C, IF/ID flushed.
5. While halted, apply a redirect to 32'h0000_0040 (out of range). Required: stays in HALT. Then a redirect to 0: halted drops and word 0 is fetched.
6. Assert reset for one cycle in mid-run at pc = 16. Required: all outputs return to their reset values, then the sequence restarts from RESET_PC. With FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives IMEM word address, fills IF/ID.
// Optional perf counters enabled with `define FETCH_PERF_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PROG_LEN = 9,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] im_instruction,
  output logic [3:0]  im_address,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch_count,
  output logic [15:0] perf_stall_count
`endif
);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] tgt;

  function automatic logic in_range(input logic [31:0] a);
    return (a >> 2) < 32'(PROG_LEN);
  endfunction

  assign pc_nxt     = pc + 32'd4;
  assign tgt        = redirect_target & ~32'h3;
  assign im_address = pc[5:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= FILL;
      if_instr    <= NOP_WORD;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
`ifdef FETCH_PERF_EN
      perf_fetch_count <= '0;
      perf_stall_count <= '0;
`endif
    end else if (redirect_valid) begin
      // flush keeps if_pc/if_pc_plus4 from the last real fetch
      pc       <= tgt;
      if_instr <= NOP_WORD;
      if_valid <= 1'b0;
      state    <= in_range(tgt) ? RUN : HALT;
      halted   <= !in_range(tgt);
    end else begin
      unique case (state)
        FILL: begin
          if_instr <= NOP_WORD;
          if_valid <= 1'b0;
          state    <= in_range(pc) ? RUN : HALT;
          halted   <= !in_range(pc);
        end
        RUN: begin
          if (stall) begin
`ifdef FETCH_PERF_EN
            if (perf_stall_count != 16'hFFFF)
              perf_stall_count <= perf_stall_count + 16'd1;
`endif
          end else begin
            if_instr    <= im_instruction;
            if_pc       <= pc;
            if_pc_plus4 <= pc_nxt;
            if_valid    <= 1'b1;
            pc          <= pc_nxt;
            if (!in_range(pc_nxt)) begin
              state  <= HALT;
              halted <= 1'b1;
            end
`ifdef FETCH_PERF_EN
            if (perf_fetch_count != 16'hFFFF)
              perf_fetch_count <= perf_fetch_count + 16'd1;
`endif
          end
        end
        HALT: begin
          if_instr <= NOP_WORD;
          if_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected IF/ID contents per cycle
// are queued when stimulus is driven and compared after the clock edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] im_instruction;
  logic [3:0]  im_address;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_count;
  logic [15:0] perf_stall_count;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  addr;
    int          h;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign im_instruction = 32'h1000_0000 + {28'd0, im_address};

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .im_instruction  (im_instruction),
    .im_address      (im_address),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_valid        (if_valid),
    .halted          (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_count(perf_fetch_count),
    .perf_stall_count(perf_stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  // drive one cycle, queue its expectation, compare after the edge
  task automatic cyc(input string tag, input bit r, input bit st,
                     input bit rv, input logic [31:0] tg, input bit ev,
                     input logic [31:0] ei, input logic [31:0] ep,
                     input logic [3:0] ea, input int eh);
    exp_t e;
    reset           = r;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = tg;
    sb.push_back('{v: ev, instr: ei, pc: ep, addr: ea, h: eh});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, e.v});
      check({tag, ".instr"}, if_instr, e.instr);
      check({tag, ".pc"}, if_pc, e.pc);
      check({tag, ".addr"}, {28'd0, im_address}, {28'd0, e.addr});
      if (e.v)
        check({tag, ".pc4"}, if_pc_plus4, e.pc + 32'd4);
      if (e.h >= 0)
        check({tag, ".halted"}, {31'd0, halted}, 32'(e.h));
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    @(negedge clk);

    // reset state and bubble
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst.pc4", if_pc_plus4, 32'd0);
`ifdef FETCH_PERF_EN
    check("rst.pfetch", {16'd0, perf_fetch_count}, 32'd0);
    check("rst.pstall", {16'd0, perf_stall_count}, 32'd0);
`endif
    cyc("fill", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // free run to end of program
    for (int i = 0; i < 8; i++)
      cyc("run", 0, 0, 0, 0, 1, w(i), 32'(4 * i), 4'(i + 1), 0);
    cyc("last", 0, 0, 0, 0, 1, w(8), 32'd32, 4'd9, -1);
    cyc("halt", 0, 0, 0, 0, 0, 0, 32'd32, 4'd9, 1);
    cyc("halt2", 0, 0, 0, 0, 0, 0, 32'd32, 4'd9, 1);

    // redirect while halted: out of range stays halted, 0 restarts
    cyc("hredir40", 0, 0, 1, 32'h40, 0, 0, 32'd32, 4'd0, 1);
    cyc("hredir0", 0, 0, 1, 32'h0, 0, 0, 32'd32, 4'd0, 0);
    cyc("w0", 0, 0, 0, 0, 1, w(0), 32'd0, 4'd1, 0);
    cyc("w1", 0, 0, 0, 0, 1, w(1), 32'd4, 4'd2, 0);
    cyc("w2", 0, 0, 0, 0, 1, w(2), 32'd8, 4'd3, 0);

    // three stall cycles at if_pc = 8
    for (int i = 0; i < 3; i++)
      cyc("stall", 0, 1, 0, 0, 1, w(2), 32'd8, 4'd3, 0);
`ifdef FETCH_PERF_EN
    check("pstall", {16'd0, perf_stall_count}, 32'd3);
`endif
    cyc("resume", 0, 0, 0, 0, 1, w(3), 32'd12, 4'd4, 0);
    cyc("w4", 0, 0, 0, 0, 1, w(4), 32'd16, 4'd5, 0);

    // redirect at pc = 20 back to word 1
    cyc("redir4", 0, 0, 1, 32'h4, 0, 0, 32'd16, 4'd1, 0);
    cyc("w1b", 0, 0, 0, 0, 1, w(1), 32'd4, 4'd2, 0);

    // redirect beats stall, misaligned target aligned down
    cyc("redir1e", 0, 1, 1, 32'h1E, 0, 0, 32'd4, 4'd7, 0);
    cyc("w7", 0, 0, 0, 0, 1, w(7), 32'h1C, 4'd8, 0);
    cyc("w8", 0, 0, 0, 0, 1, w(8), 32'd32, 4'd9, -1);
    cyc("halt3", 0, 0, 0, 0, 0, 0, 32'd32, 4'd9, 1);

    // restart, then mid-run reset at pc = 16
    cyc("redir0b", 0, 0, 1, 32'h0, 0, 0, 32'd32, 4'd0, 0);
    for (int i = 0; i < 4; i++)
      cyc("rerun", 0, 0, 0, 0, 1, w(i), 32'(4 * i), 4'(i + 1), 0);
    cyc("midrst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("midrst.pc4", if_pc_plus4, 32'd0);
`ifdef FETCH_PERF_EN
    check("midrst.pfetch", {16'd0, perf_fetch_count}, 32'd0);
    check("midrst.pstall", {16'd0, perf_stall_count}, 32'd0);
`endif
    cyc("fill2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("w0c", 0, 0, 0, 0, 1, w(0), 32'd0, 4'd1, 0);
    cyc("w1c", 0, 0, 0, 0, 1, w(1), 32'd4, 4'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
